// File: rtl/bram_dp_ram_ctrl.sv
// bram_dp_ram_ctrl: parametrised true dual-port RAM with two slave ports,
// per-port read pipeline, cross-port collision handling and reset clear.
module bram_dp_ram_ctrl #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 10,
    parameter int READ_LATENCY = 1,
    parameter int RDW_MODE     = 0,
    parameter int INIT_CLEAR   = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   address,
    input  logic                chipselect,
    input  logic                clken,
    input  logic                write,
    input  logic [DATA_W-1:0]   writedata,
    input  logic [DATA_W/8-1:0] byteenable,
    output logic [DATA_W-1:0]   readdata,
    output logic                readdatavalid,
    output logic                waitrequest,
    input  logic [ADDR_W-1:0]   address2,
    input  logic                chipselect2,
    input  logic                clken2,
    input  logic                write2,
    input  logic [DATA_W-1:0]   writedata2,
    input  logic [DATA_W/8-1:0] byteenable2,
    output logic [DATA_W-1:0]   readdata2,
    output logic                readdatavalid2,
    output logic                waitrequest2
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    typedef enum logic {CLEAR, READY} state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              acc1, acc2;
    logic              we1, we2;
    logic              re1, re2;
    logic              clr_we;
    logic [DATA_W-1:0] rword1, rword2;
    logic              vld1, vld2;

    // Accepted requests; nothing is taken while reset is held.
    assign acc1   = chipselect & clken & ~waitrequest & ~reset;
    assign acc2   = chipselect2 & clken2 & ~waitrequest2 & ~reset;
    assign we1    = acc1 & write;
    assign we2    = acc2 & write2;
    assign re1    = acc1 & ~write;
    assign re2    = acc2 & ~write2;
    assign clr_we = (state == CLEAR) & ~reset;

    // A stalled port hides its pending valid until clken returns.
    assign readdatavalid  = vld1 & clken;
    assign readdatavalid2 = vld2 & clken2;

    // Clear sequencer: walk every address once, then serve until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= (INIT_CLEAR != 0) ? CLEAR : READY;
            clr_cnt      <= '0;
            waitrequest  <= (INIT_CLEAR != 0);
            waitrequest2 <= (INIT_CLEAR != 0);
        end else begin
            case (state)
                CLEAR: begin
                    if (&clr_cnt) begin
                        state        <= READY;
                        waitrequest  <= 1'b0;
                        waitrequest2 <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= READY;
                end
            endcase
        end
    end

    // Array update: s1 owns any lane it enables on a shared address.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_cnt] <= '0;
        end
        for (int b = 0; b < NB; b++) begin
            if (we1 && byteenable[b]) begin
                mem[address][b*8 +: 8] <= writedata[b*8 +: 8];
            end
            if (we2 && byteenable2[b] &&
                !(we1 && byteenable[b] && address == address2)) begin
                mem[address2][b*8 +: 8] <= writedata2[b*8 +: 8];
            end
        end
    end

    // Read word per port, optionally forwarding the other port's write.
    always_comb begin
        rword1 = mem[address];
        rword2 = mem[address2];
        if (RDW_MODE != 0) begin
            for (int b = 0; b < NB; b++) begin
                if (we2 && byteenable2[b] && address2 == address) begin
                    rword1[b*8 +: 8] = writedata2[b*8 +: 8];
                end
                if (we1 && byteenable[b] && address == address2) begin
                    rword2[b*8 +: 8] = writedata[b*8 +: 8];
                end
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_W-1:0] p1_data, p2_data;
            logic              p1_vld, p2_vld;

            // s1 two-stage read pipeline, frozen while clken is low.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    p1_data  <= '0;
                    p1_vld   <= 1'b0;
                    readdata <= '0;
                    vld1     <= 1'b0;
                end else if (clken) begin
                    p1_vld <= re1;
                    if (re1) begin
                        p1_data <= rword1;
                    end
                    vld1 <= p1_vld;
                    if (p1_vld) begin
                        readdata <= p1_data;
                    end
                end
            end

            // s2 two-stage read pipeline, frozen while clken2 is low.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    p2_data   <= '0;
                    p2_vld    <= 1'b0;
                    readdata2 <= '0;
                    vld2      <= 1'b0;
                end else if (clken2) begin
                    p2_vld <= re2;
                    if (re2) begin
                        p2_data <= rword2;
                    end
                    vld2 <= p2_vld;
                    if (p2_vld) begin
                        readdata2 <= p2_data;
                    end
                end
            end
        end else begin : g_lat1
            // s1 single-stage read register, frozen while clken is low.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    readdata <= '0;
                    vld1     <= 1'b0;
                end else if (clken) begin
                    vld1 <= re1;
                    if (re1) begin
                        readdata <= rword1;
                    end
                end
            end

            // s2 single-stage read register, frozen while clken2 is low.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    readdata2 <= '0;
                    vld2      <= 1'b0;
                end else if (clken2) begin
                    vld2 <= re2;
                    if (re2) begin
                        readdata2 <= rword2;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_bram_dp_ram_ctrl.sv
// tb_bram_dp_ram_ctrl: two instances share stimulus; A is latency 1 with
// old-data collisions, B is latency 2 with new-data collisions.
module tb_bram_dp_ram_ctrl;

    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] address = '0, address2 = '0;
    logic          chipselect = 1'b0, chipselect2 = 1'b0;
    logic          clken = 1'b1, clken2 = 1'b1;
    logic          write = 1'b0, write2 = 1'b0;
    logic [DW-1:0] writedata = '0, writedata2 = '0;
    logic [3:0]    byteenable = '0, byteenable2 = '0;

    logic [DW-1:0] rd_a, rd2_a, rd_b, rd2_b;
    logic          rv_a, rv2_a, rv_b, rv2_b;
    logic          wr_a, wr2_a, wr_b, wr2_b;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bram_dp_ram_ctrl #(
        .DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(1),
        .RDW_MODE(0), .INIT_CLEAR(1)
    ) dut_a (
        .clk(clk), .reset(reset),
        .address(address), .chipselect(chipselect), .clken(clken),
        .write(write), .writedata(writedata), .byteenable(byteenable),
        .readdata(rd_a), .readdatavalid(rv_a), .waitrequest(wr_a),
        .address2(address2), .chipselect2(chipselect2), .clken2(clken2),
        .write2(write2), .writedata2(writedata2), .byteenable2(byteenable2),
        .readdata2(rd2_a), .readdatavalid2(rv2_a), .waitrequest2(wr2_a)
    );

    bram_dp_ram_ctrl #(
        .DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(2),
        .RDW_MODE(1), .INIT_CLEAR(1)
    ) dut_b (
        .clk(clk), .reset(reset),
        .address(address), .chipselect(chipselect), .clken(clken),
        .write(write), .writedata(writedata), .byteenable(byteenable),
        .readdata(rd_b), .readdatavalid(rv_b), .waitrequest(wr_b),
        .address2(address2), .chipselect2(chipselect2), .clken2(clken2),
        .write2(write2), .writedata2(writedata2), .byteenable2(byteenable2),
        .readdata2(rd2_b), .readdatavalid2(rv2_b), .waitrequest2(wr2_b)
    );

    typedef struct {
        bit          p2;
        bit          wr;
        logic [3:0]  a;
        logic [31:0] d;
        logic [3:0]  be;
        logic [31:0] e;
    } vec_t;

    vec_t tbl[14];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Observed {valid, data} of a port; b selects instance B.
    function automatic logic [32:0] obs(input bit b, input int p);
        if (!b) return (p == 1) ? {rv_a, rd_a} : {rv2_a, rd2_a};
        return (p == 1) ? {rv_b, rd_b} : {rv2_b, rd2_b};
    endfunction

    task automatic chk_v(input string nm, input logic [32:0] o,
                         input logic ev, input logic [31:0] ed);
        n_chk++;
        if (o[32] !== ev || (ev && o[31:0] !== ed)) begin
            n_fail++;
            $display("FAIL %s: got valid %b data %h expected valid %b data %h",
                     nm, o[32], o[31:0], ev, ed);
        end
    endtask

    task automatic wr(input int p, input logic [3:0] a,
                      input logic [31:0] d, input logic [3:0] be);
        if (p == 1) begin
            chipselect = 1; write = 1; address = a;
            writedata = d; byteenable = be;
        end else begin
            chipselect2 = 1; write2 = 1; address2 = a;
            writedata2 = d; byteenable2 = be;
        end
        step();
        chipselect = 0; write = 0;
        chipselect2 = 0; write2 = 0;
    endtask

    // p: 1 = s1, 2 = s2, 3 = both ports on the same address.
    task automatic rd(input int p, input logic [3:0] a, input logic [31:0] e);
        logic [32:0] o;
        if ((p & 1) != 0) begin chipselect = 1; write = 0; address = a; end
        if ((p & 2) != 0) begin chipselect2 = 1; write2 = 0; address2 = a; end
        step();
        chipselect = 0; chipselect2 = 0;
        for (int q = 1; q <= 2; q++) if ((p & q) != 0) begin
            chk_v($sformatf("rd A s%0d @%0d", q, a), obs(0, q), 1'b1, e);
            chk_v($sformatf("rd B early s%0d @%0d", q, a), obs(1, q), 1'b0, e);
        end
        step();
        for (int q = 1; q <= 2; q++) if ((p & q) != 0) begin
            chk_v($sformatf("rd A pulse s%0d @%0d", q, a), obs(0, q), 1'b0, e);
            chk_v($sformatf("rd B s%0d @%0d", q, a), obs(1, q), 1'b1, e);
        end
        step();
        for (int q = 1; q <= 2; q++) if ((p & q) != 0) begin
            o = obs(1, q);
            chk_v($sformatf("rd B pulse s%0d @%0d", q, a), o, 1'b0, e);
            chk($sformatf("rd B hold s%0d @%0d", q, a), o[31:0], e);
        end
    endtask

    task automatic clear_wait(input string nm);
        int n;
        int mism;
        n = 0;
        mism = 0;
        while (wr_a === 1'b1 && n < 40) begin
            n++;
            if (wr2_a !== wr_a || wr_b !== wr_a || wr2_b !== wr_a) mism++;
            step();
        end
        chk({nm, " wait cycles"}, n, 16);
        chk({nm, " wait agree"}, mism, 0);
        chk({nm, " wait low"}, {wr_a, wr2_a, wr_b, wr2_b}, 0);
    endtask

    initial begin
        logic [31:0] dq[3];
        int ea[8], eb[8], cl_n[8], cs_n[8], ad_n[8];
        int na, nb;

        tbl[0]  = '{1'b0, 1'b1, 4'd5, 32'hDEADBEEF, 4'hF, 32'h0};
        tbl[1]  = '{1'b0, 1'b1, 4'd5, 32'h000000AA, 4'h1, 32'h0};
        tbl[2]  = '{1'b0, 1'b0, 4'd5, 32'h0, 4'h0, 32'hDEADBEAA};
        tbl[3]  = '{1'b1, 1'b0, 4'd5, 32'h0, 4'h0, 32'hDEADBEAA};
        tbl[4]  = '{1'b1, 1'b1, 4'd0, 32'h00000100, 4'hF, 32'h0};
        tbl[5]  = '{1'b0, 1'b1, 4'd1, 32'h00000101, 4'hF, 32'h0};
        tbl[6]  = '{1'b0, 1'b1, 4'd2, 32'h00000102, 4'hF, 32'h0};
        tbl[7]  = '{1'b0, 1'b0, 4'd0, 32'h0, 4'h0, 32'h00000100};
        tbl[8]  = '{1'b1, 1'b1, 4'd2, 32'hFFFFFFFF, 4'h4, 32'h0};
        tbl[9]  = '{1'b0, 1'b0, 4'd2, 32'h0, 4'h0, 32'h00FF0102};
        tbl[10] = '{1'b1, 1'b0, 4'd1, 32'h0, 4'h0, 32'h00000101};
        tbl[11] = '{1'b0, 1'b1, 4'd7, 32'hA5A5A5A5, 4'hF, 32'h0};
        tbl[12] = '{1'b1, 1'b0, 4'd7, 32'h0, 4'h0, 32'hA5A5A5A5};
        tbl[13] = '{1'b0, 1'b0, 4'd9, 32'h0, 4'h0, 32'h0};

        // Reset values with reset held across clock edges.
        step();
        step();
        chk("reset rd", {rd_a, rd2_a} | {rd_b, rd2_b}, 0);
        chk("reset rv", {rv_a, rv2_a, rv_b, rv2_b}, 0);
        chk("reset wait", {wr_a, wr2_a, wr_b, wr2_b}, 4'hF);
        reset = 0;
        clear_wait("init");

        for (int a = 0; a < 16; a++) rd(3, 4'(a), 32'h0);

        foreach (tbl[i]) begin
            if (tbl[i].wr) wr(tbl[i].p2 ? 2 : 1, tbl[i].a, tbl[i].d, tbl[i].be);
            else rd(tbl[i].p2 ? 2 : 1, tbl[i].a, tbl[i].e);
        end

        // Same-cycle writes to one address merge per lane.
        chipselect = 1; write = 1; address = 3;
        writedata = 32'h11111111; byteenable = 4'h3;
        chipselect2 = 1; write2 = 1; address2 = 3;
        writedata2 = 32'h22222222; byteenable2 = 4'hE;
        step();
        chipselect = 0; write = 0; chipselect2 = 0; write2 = 0;
        rd(3, 3, 32'h22221111);

        // Cross-port read during write on address 7.
        chipselect = 1; write = 1; address = 7;
        writedata = 32'h5A5A5A5A; byteenable = 4'hF;
        chipselect2 = 1; write2 = 0; address2 = 7;
        step();
        chipselect = 0; write = 0; chipselect2 = 0;
        chk_v("rdw A old", obs(0, 2), 1'b1, 32'hA5A5A5A5);
        step();
        chk_v("rdw B new", obs(1, 2), 1'b1, 32'h5A5A5A5A);
        step();
        rd(3, 7, 32'h5A5A5A5A);

        // s1 reads 0,1,2 with a 3-cycle clken stall; s2 streams reads of 5.
        dq = '{32'h00000100, 32'h00000101, 32'h00FF0102};
        ea = '{1, 0, 0, 0, 1, 1, 0, 0};
        eb = '{0, 0, 0, 0, 1, 1, 1, 0};
        cl_n = '{1, 0, 0, 0, 1, 1, 1, 1};
        cs_n = '{1, 0, 0, 0, 1, 0, 0, 0};
        ad_n = '{1, 0, 0, 0, 2, 0, 0, 0};
        na = 0;
        nb = 0;
        chipselect = 1; write = 0; address = 0; clken = 1;
        chipselect2 = 1; write2 = 0; address2 = 5;
        for (int i = 0; i < 8; i++) begin
            step();
            clken = cl_n[i][0];
            chipselect = cs_n[i][0];
            address = 4'(ad_n[i]);
            chipselect2 = (i < 5);
            #1;
            chk($sformatf("stall A v c%0d", i), rv_a, ea[i]);
            chk($sformatf("stall B v c%0d", i), rv_b, eb[i]);
            if (rv_a) begin
                if (na < 3) chk($sformatf("stall A d%0d", na), rd_a, dq[na]);
                na++;
            end
            if (rv_b) begin
                if (nb < 3) chk($sformatf("stall B d%0d", nb), rd_b, dq[nb]);
                nb++;
            end
            chk_v($sformatf("stall A s2 c%0d", i), obs(0, 2),
                  (i <= 5), 32'hDEADBEAA);
            chk_v($sformatf("stall B s2 c%0d", i), obs(1, 2),
                  (i >= 1 && i <= 6), 32'hDEADBEAA);
        end
        chk("stall A pulses", na, 3);
        chk("stall B pulses", nb, 3);
        clken = 1; chipselect = 0; chipselect2 = 0;
        step();

        // Reset at clear count 9 restarts the whole clear.
        wr(1, 12, 32'hCAFE0012, 4'hF);
        rd(1, 12, 32'hCAFE0012);
        reset = 1;
        #1;
        chk("async reset wait", {wr_a, wr_b}, 2'b11);
        chk("async reset rd", {rd_a, rd_b}, 0);
        step();
        reset = 0;
        repeat (9) step();
        reset = 1;
        step();
        reset = 0;
        clear_wait("re-clear");
        for (int a = 0; a < 16; a++) rd(3, 4'(a), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
